// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - end-of-test monitor: pass/fail/timeout status, fail number, cycle/instret counts
module riscv_test_monitor #(
    parameter int              XLEN           = 32,
    parameter int              MODE           = 0,
    parameter logic [XLEN-1:0] HALT_PC        = 32'h44,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h1000,
    parameter int              TIMEOUT_CYCLES = 5000,
    parameter int              CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  gp,
    input  logic             st_we,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             done,
    output logic             done_pulse,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  fail_num,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic {S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [XLEN-1:0]  CODE_OK  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state, state_nx;
    logic              evt;
    logic              to_evt;
    logic [XLEN-1:0]   code;
    logic [CNT_W-1:0]  cycles_inc;
    logic [CNT_W-1:0]  instret_inc;

    always_comb begin
        evt         = 1'b0;
        code        = gp;
        to_evt      = 1'b0;
        state_nx    = state;
        cycles_inc  = (cycles  == CNT_MAX) ? cycles  : cycles  + 1'b1;
        instret_inc = (instret == CNT_MAX) ? instret : instret + 1'b1;
        if (MODE == 0) begin
            evt  = retire && (pc == HALT_PC);
            code = gp;
        end else begin
            // stores with bit 0 clear are syscalls, not completions
            evt  = st_we && (st_addr == TOHOST_ADDR) && st_data[0];
            code = st_data;
        end
        // completion takes priority over a coincident timeout
        to_evt = (TIMEOUT_CYCLES != 0) && (cycles == TO_LAST) && !evt;
        if (state == S_RUN && (evt || to_evt))
            state_nx = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_RUN;
            done       <= 1'b0;
            done_pulse <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            fail_num   <= '0;
            cycles     <= '0;
            instret    <= '0;
        end else begin
            state      <= state_nx;
            done_pulse <= 1'b0;
            if (state == S_RUN) begin
                cycles <= cycles_inc;
                if (retire)
                    instret <= instret_inc;
                if (evt) begin
                    done       <= 1'b1;
                    done_pulse <= 1'b1;
                    if (code == CODE_OK) begin
                        pass <= 1'b1;
                    end else begin
                        fail     <= 1'b1;
                        fail_num <= code >> 1;
                    end
                end else if (to_evt) begin
                    done       <= 1'b1;
                    done_pulse <= 1'b1;
                    timeout    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb/tb_riscv_test_monitor.sv - directed-vector bench for riscv_test_monitor
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire;
    logic [31:0] pc, gp;
    logic        st_we;
    logic [31:0] st_addr, st_data;

    // u0: halt-PC mode, default budget
    logic o0_done, o0_pulse, o0_pass, o0_fail, o0_to;
    logic [31:0] o0_fnum, o0_cyc, o0_ins;
    // u1: tohost mode
    logic o1_done, o1_pulse, o1_pass, o1_fail, o1_to;
    logic [31:0] o1_fnum, o1_cyc, o1_ins;
    // u2: halt-PC mode, 16-cycle budget
    logic o2_done, o2_pulse, o2_pass, o2_fail, o2_to;
    logic [31:0] o2_fnum, o2_cyc, o2_ins;
    // u3: 4-bit counters, no budget, unreachable halt PC
    logic o3_done, o3_pulse, o3_pass, o3_fail, o3_to;
    logic [31:0] o3_fnum;
    logic [3:0]  o3_cyc, o3_ins;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_test_monitor #(.MODE(0)) u0 (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .gp(gp),
        .st_we(st_we), .st_addr(st_addr), .st_data(st_data),
        .done(o0_done), .done_pulse(o0_pulse), .pass(o0_pass), .fail(o0_fail),
        .timeout(o0_to), .fail_num(o0_fnum), .cycles(o0_cyc), .instret(o0_ins));

    riscv_test_monitor #(.MODE(1)) u1 (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .gp(gp),
        .st_we(st_we), .st_addr(st_addr), .st_data(st_data),
        .done(o1_done), .done_pulse(o1_pulse), .pass(o1_pass), .fail(o1_fail),
        .timeout(o1_to), .fail_num(o1_fnum), .cycles(o1_cyc), .instret(o1_ins));

    riscv_test_monitor #(.MODE(0), .TIMEOUT_CYCLES(16)) u2 (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .gp(gp),
        .st_we(st_we), .st_addr(st_addr), .st_data(st_data),
        .done(o2_done), .done_pulse(o2_pulse), .pass(o2_pass), .fail(o2_fail),
        .timeout(o2_to), .fail_num(o2_fnum), .cycles(o2_cyc), .instret(o2_ins));

    riscv_test_monitor #(.MODE(0), .HALT_PC(32'hFFFC), .TIMEOUT_CYCLES(0), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .gp(gp),
        .st_we(st_we), .st_addr(st_addr), .st_data(st_data),
        .done(o3_done), .done_pulse(o3_pulse), .pass(o3_pass), .fail(o3_fail),
        .timeout(o3_to), .fail_num(o3_fnum), .cycles(o3_cyc), .instret(o3_ins));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        retire = 1'b0; pc = 32'h0; gp = 32'h0;
        st_we = 1'b0; st_addr = 32'h0; st_data = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic halt(input logic [31:0] code);
        retire = 1'b1; pc = 32'h44; gp = code;
    endtask

    task automatic tohost(input logic [31:0] addr, input logic [31:0] data);
        st_we = 1'b1; st_addr = addr; st_data = data;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        tick();
        // reset held low must dominate a matching halt retire
        halt(32'h1);
        tohost(32'h1000, 32'h1);
        tick();
        tick();
        check("rst_done",    o0_done,  0);
        check("rst_pass",    o0_pass,  0);
        check("rst_cycles",  o0_cyc,   0);
        check("rst_instret", o0_ins,   0);
        check("rst_u1_pass", o1_pass,  0);

        // run 1: 10 retires, halt at cycle 20; u2 times out at 16
        rst = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            idle();
            if (i < 10) begin retire = 1'b1; pc = 32'h100 + 32'(4 * i); end
            if (i == 5) tohost(32'h1000, 32'h2);
            if (i == 7) tohost(32'h1004, 32'h1);
            if (i == 20) halt(32'h1);
            tick();
            if (i == 8)  check("u1_syscall_ignored", o1_done, 0);
            if (i == 14) check("to_not_early", o2_done, 0);
            if (i == 15) begin
                check("to_timeout", o2_to,    1);
                check("to_done",    o2_done,  1);
                check("to_pulse",   o2_pulse, 1);
                check("to_cycles",  o2_cyc,   16);
            end
            if (i == 16) begin
                check("to_pulse_off",   o2_pulse, 0);
                check("to_cycles_hold", o2_cyc,   16);
                check("to_pass",        o2_pass,  0);
            end
            if (i == 19) begin
                check("sat_cycles", o3_cyc,  15);
                check("sat_done",   o3_done, 0);
                check("p_not_yet",  o0_done, 0);
            end
        end
        check("p_done",    o0_done,  1);
        check("p_pass",    o0_pass,  1);
        check("p_fail",    o0_fail,  0);
        check("p_timeout", o0_to,    0);
        check("p_pulse",   o0_pulse, 1);
        check("p_instret", o0_ins,   11);
        check("p_cycles",  o0_cyc,   21);
        check("to_instret_frozen", o2_ins, 10);
        check("to_ignores_halt",   o2_pass, 0);
        idle();
        tick();
        check("p_pulse_off",   o0_pulse, 0);
        check("p_cycles_hold", o0_cyc,   21);
        check("sat_cycles_hold", o3_cyc, 15);
        tohost(32'h1000, 32'h1);
        tick();
        check("th_pass",  o1_pass, 1);
        check("th_fail",  o1_fail, 0);
        check("th_fnum",  o1_fnum, 0);

        // reset in DONE, then failing codes in both modes
        idle();
        rst = 1'b0;
        tick();
        check("rd_done",    o0_done, 0);
        check("rd_pass",    o0_pass, 0);
        check("rd_cycles",  o0_cyc,  0);
        check("rd_u1_pass", o1_pass, 0);
        check("rd_u2_to",   o2_to,   0);
        rst = 1'b1;
        tick(); tick(); tick();
        halt(32'h7);
        tohost(32'h1000, 32'hB);
        tick();
        check("f_fail",    o0_fail, 1);
        check("f_pass",    o0_pass, 0);
        check("f_fnum",    o0_fnum, 3);
        check("f_instret", o0_ins,  1);
        check("f_cycles",  o0_cyc,  4);
        check("thf_fail",  o1_fail, 1);
        check("thf_fnum",  o1_fnum, 5);
        halt(32'h1);
        tohost(32'h1000, 32'h1);
        tick();
        check("f_frozen_pass",  o0_pass, 0);
        check("f_frozen_fnum",  o0_fnum, 3);
        check("f_frozen_cyc",   o0_cyc,  4);
        check("thf_frozen",     o1_pass, 0);

        // mid-run reset, then tie of completion with the last budget cycle
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mr_cycles_pre", o0_cyc, 5);
        rst = 1'b0;
        tick();
        check("mr_cycles", o0_cyc,  0);
        check("mr_done",   o0_done, 0);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        halt(32'h1);
        tick();
        check("tie_pass",    o2_pass, 1);
        check("tie_timeout", o2_to,   0);
        check("tie_cycles",  o2_cyc,  16);
        check("mr_pass",     o0_pass, 1);
        check("mr_instret",  o0_ins,  1);
        check("mr_cyc_end",  o0_cyc,  16);

        // code 0 in halt-PC mode is a failure with test number 0
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        halt(32'h0);
        tick();
        check("z_fail", o0_fail, 1);
        check("z_pass", o0_pass, 0);
        check("z_fnum", o0_fnum, 0);
        check("z_done", o0_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable end-of-test monitor for riscv-tests runs on the RV32 core. It replaces bench-side PC polling with registered pass/fail/timeout status, the failing test number, and cycle/instret counts. It supports two completion modes: halt-PC match with gp, or a tohost store. It sits beside `Core`, taps the retire stream and the store bus, and can be instantiated in simulation benches or in an FPGA wrapper driving LEDs/UART.

## Interface
- XLEN, 32, data/address width of pc, gp and tohost data
- MODE, 0, 0 = halt-PC mode (retired pc == HALT_PC), 1 = tohost mode (store to TOHOST_ADDR)
- HALT_PC, 32'h44, address of the riscv-tests pass/fail trap handler (MODE 0)
- TOHOST_ADDR, 32'h1000, tohost word address (MODE 1)
- TIMEOUT_CYCLES, 5000, cycle budget; 0 disables timeout
- CNT_W, 32, width of cycle and instret counters
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset
- retire  in  1  one instruction retires this cycle
- pc  in  XLEN  pc of the retiring instruction, qualified by retire
- gp  in  XLEN  architectural x3 value, sampled with retire
- st_we  in  1  data-memory store strobe
- st_addr  in  XLEN  store address, qualified by st_we
- st_data  in  XLEN  store data, qualified by st_we
- done  out  1  sticky; test finished (pass, fail or timeout)
- done_pulse  out  1  one-cycle pulse on entry to DONE
- pass  out  1  sticky; test passed
- fail  out  1  sticky; test failed
- timeout  out  1  sticky; budget exhausted
- fail_num  out  XLEN  failing test number (code >> 1); 0 unless fail
- cycles  out  CNT_W  cycles spent in RUN
- instret  out  CNT_W  retired instructions counted in RUN

## Operation
- States: RUN, DONE. Reset (rst == 0 at posedge) enters RUN and clears all outputs and counters to 0.
- In RUN:
  - cycles increments by 1 each cycle.
  - instret increments when retire == 1.
  - Both counters saturate at all-ones and never wrap.
- Completion event, MODE 0: retire == 1 && pc == HALT_PC; the code is gp.
- Completion event, MODE 1: st_we == 1 && st_addr == TOHOST_ADDR && st_data[0] == 1; the code is st_data.
- MODE 1: tohost stores with st_data[0] == 0 are syscalls and are ignored.
- Resolution of a completion event:
  - code == 1 → pass = 1.
  - Any other code → fail = 1 and fail_num = code >> 1 (logical shift).
  - Code 0 in MODE 0 counts as fail, with fail_num = 0.
- Timeout event: TIMEOUT_CYCLES != 0 and cycles == TIMEOUT_CYCLES - 1 in RUN with no completion event → timeout = 1.
- Simultaneous completion and timeout in the same cycle: completion wins, and timeout stays 0.
- Any event sets done = 1, pulses done_pulse, and moves to DONE.
- In DONE:
  - All status outputs and counters are frozen.
  - Further retire, store or pc matches are ignored.
  - Only reset leaves DONE.
- Exactly one of pass/fail/timeout is 1 whenever done == 1; all three are 0 while done == 0.

## Timing
- All outputs are registered. An event sampled at posedge N is visible after posedge N, i.e. during cycle N+1.
- The counter value in the event cycle is included: the completing instruction counts in instret, and the event cycle counts in cycles.
- done_pulse is high for exactly one cycle, the first cycle done == 1.
- Reset mid-run or in DONE clears everything at that posedge. RUN restarts counting on the first posedge with rst == 1.
- rst held low keeps all outputs at 0 regardless of other inputs.
- No combinational path from any input to any output.

## Test plan
- MODE 0 pass: retire 10 instructions, then retire pc=0x44 with gp=1 on cycle 20 → the next cycle shows done=1, pass=1, done_pulse=1 for exactly one cycle, and instret=11, cycles=21.
- MODE 0 fail: retire pc=0x44 with gp=0x0000_0007 → fail=1, fail_num=3, pass=0. A later retire at pc=0x44 with gp=1 changes nothing.
- MODE 1 tohost:
  - Store st_data=0x2 to 0x1000 → ignored, state stays RUN.
  - Then store st_data=0x1 → pass=1.
  - In a separate run, st_data=0xB → fail=1, fail_num=5.
  - A store to 0x1004 is ignored.
- Timeout: TIMEOUT_CYCLES=16 with no event → timeout=1 visible after the 16th RUN cycle, cycles=16 frozen afterwards.
- Tie case: completion on the same cycle as cycles==15 → pass=1, timeout=0.
- Reset: assert rst=0 for one cycle mid-run, and again in DONE → all outputs 0 the next cycle; the counters restart from 0 and a subsequent pass is reported normally.
- Saturation: CNT_W=4 with TIMEOUT_CYCLES=0 → cycles holds at 15 and does not wrap after 20 cycles.
